// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg -- shared definitions for the load/store unit.
//   SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILLEGAL : req_size encodings
//   WORD_OFFSET : number of byte-address bits below the word address
//   lsu_state_t : load/store unit FSM states
//   is_misaligned() : alignment rule used when LSU_ALIGN_CHECK_EN is defined
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam int WORD_OFFSET = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } lsu_state_t;

  // Halfwords must sit on an even address, words on a multiple of four;
  // the reserved size code is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SZ_HALF:    return addr_lo[0];
      SZ_WORD:    return (addr_lo != 2'b00);
      SZ_ILLEGAL: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if -- request/response channel between the MEM pipeline
// stage (master) and the load/store unit (slave).
//   req_valid/req_ready : request handshake (stall = ~req_ready)
//   req_we, req_size, req_signed, req_addr, req_wdata : request fields
//   rsp_valid, rsp_rdata, rsp_err : one-cycle completion, load data, fault
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align -- combinational byte-lane logic of the load/store unit.
//   size        : effective access size (SZ_BYTE / SZ_HALF / word)
//   byte_off    : low two address bits selecting the lane (little-endian)
//   is_signed   : sign-extend sub-word loads
//   mem_word    : word read from RAM
//   store_data  : right-justified store data
//   load_data   : selected lane, right-justified and extended
//   merged_word : mem_word with only the addressed lane(s) replaced
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  byte_off,
  input  logic        is_signed,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val    = mem_word[{byte_off, 3'b000} +: 8];
    half_val    = byte_off[1] ? mem_word[31:16] : mem_word[15:0];
    load_data   = mem_word;
    merged_word = store_data;
    case (size)
      SZ_BYTE: begin
        load_data   = {{24{is_signed & byte_val[7]}}, byte_val};
        merged_word = mem_word;
        merged_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
      end
      SZ_HALF: begin
        // byte_off[0] is ignored here: it is either faulted earlier or dropped
        load_data   = {{16{is_signed & half_val[15]}}, half_val};
        merged_word = mem_word;
        if (byte_off[1]) begin
          merged_word[31:16] = store_data[15:0];
        end else begin
          merged_word[15:0] = store_data[15:0];
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- multi-cycle MEM-stage load/store unit driving a
// word-addressed RAM with a combinational read port.
//   clk, reset (async, active-low)
//   bus          : load_store_unit_if.slave request/response channel
//   mem_address  : word-aligned byte address to the RAM
//   mem_data_write, mem_write_en : write port (one cycle per store)
//   mem_read_en, mem_data_out    : read strobe and combinational read data
// Optional feature: define LSU_ALIGN_CHECK_EN to fault misaligned halfword/
// word accesses and the reserved size code instead of silently dropping the
// low address bits.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_write,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_data_out
);

  lsu_state_t        state;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              we_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0]        req_size_eff;
  logic              req_fault;
  logic [ADDR_W-1:0] req_word_addr;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;

  // The reserved size code behaves as a word when it is not faulted.
  assign req_size_eff  = (bus.req_size == SZ_ILLEGAL) ? SZ_WORD : bus.req_size;
  assign req_word_addr = {bus.req_addr[ADDR_W-1:WORD_OFFSET], {WORD_OFFSET{1'b0}}};

`ifdef LSU_ALIGN_CHECK_EN
  assign req_fault = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign req_fault = 1'b0;
`endif

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // Lane logic works on the registered request and the live RAM word, so the
  // result is ready to be captured at the end of the RD cycle.
  lsu_lane_align u_lane_align (
    .size        (size_q),
    .byte_off    (addr_q[1:0]),
    .is_signed   (signed_q),
    .mem_word    (mem_data_out),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Every output is registered and set up on the transition into the state
  // that owns it, so the strobes line up exactly with RD / WR / RSP.
  // Word stores skip RD because no existing lanes need preserving.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      ready_q        <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
      mem_address    <= '0;
      mem_data_write <= '0;
      mem_write_en   <= 1'b0;
      mem_read_en    <= 1'b0;
      we_q           <= 1'b0;
      signed_q       <= 1'b0;
      size_q         <= SZ_BYTE;
      addr_q         <= '0;
      wdata_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            signed_q <= bus.req_signed;
            size_q   <= req_size_eff;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            ready_q  <= 1'b0;
            if (req_fault) begin
              state       <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (bus.req_we && (req_size_eff == SZ_WORD)) begin
              state          <= WR;
              mem_address    <= req_word_addr;
              mem_data_write <= bus.req_wdata;
              mem_write_en   <= 1'b1;
            end else begin
              state       <= RD;
              mem_address <= req_word_addr;
              mem_read_en <= 1'b1;
            end
          end
        end
        RD: begin
          mem_read_en <= 1'b0;
          if (we_q) begin
            state          <= WR;
            mem_data_write <= merged_word;
            mem_write_en   <= 1'b1;
          end else begin
            state       <= RSP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_data;
          end
        end
        WR: begin
          state        <= RSP;
          mem_write_en <= 1'b0;
          rsp_valid_q  <= 1'b1;
          rsp_rdata_q  <= '0;
        end
        RSP: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          ready_q     <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
